// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave bridging bus transactions onto a strobe/acknowledge
// register interface. One transaction in flight at a time; writes win
// over reads when both address channels are valid together.
module axi_lite_reg_slave #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_awvalid,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    output logic                  o_awready,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic [1:0]            o_bresp,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [1:0]            o_rresp,
    output logic [31:0]           o_rdata,
    output logic [ADDR_WIDTH-1:0] o_reg_address,
    input  logic                  i_reg_invalid_addr,
    output logic                  o_reg_in_rdy,
    input  logic                  i_reg_in_ack,
    output logic [31:0]           o_reg_in_data,
    output logic                  o_reg_out_req,
    input  logic                  i_reg_out_rdy,
    input  logic [31:0]           i_reg_out_data
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_DATA = 3'd1,
        ST_W_USER = 3'd2,
        ST_W_RESP = 3'd3,
        ST_R_USER = 3'd4,
        ST_R_RESP = 3'd5
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Per-cycle events decoded from the current state and bus inputs.
    logic aw_hs_s;
    logic ar_hs_s;
    logic w_hs_s;
    logic ack_s;
    logic rdy_s;
    logic b_hs_s;
    logic r_hs_s;

    // Zero every byte lane whose strobe is clear so the register block
    // never sees stale bytes from unselected lanes.
    function automatic logic [31:0] mask_wdata(input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] masked;
        masked = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            masked[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : 8'h00;
        end
        return masked;
    endfunction

    // Select the SLVERR/OKAY code from the user's invalid flag.
    function automatic logic [1:0] resp_code(input logic invalid);
        return invalid ? RESP_SLVERR : RESP_OKAY;
    endfunction

    // Ready signals follow the state directly; held low while in reset.
    assign o_awready = (state_r == ST_IDLE)   && rst;
    assign o_arready = (state_r == ST_IDLE)   && rst;
    assign o_wready  = (state_r == ST_W_DATA) && rst;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and handshake events.
    always_comb begin
        state_nxt_s = state_r;
        aw_hs_s     = 1'b0;
        ar_hs_s     = 1'b0;
        w_hs_s      = 1'b0;
        ack_s       = 1'b0;
        rdy_s       = 1'b0;
        b_hs_s      = 1'b0;
        r_hs_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_awvalid) begin
                    aw_hs_s     = 1'b1;
                    state_nxt_s = ST_W_DATA;
                end else if (i_arvalid) begin
                    ar_hs_s     = 1'b1;
                    state_nxt_s = ST_R_USER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_W_DATA: begin
                if (i_wvalid) begin
                    w_hs_s      = 1'b1;
                    state_nxt_s = ST_W_USER;
                end else begin
                    state_nxt_s = ST_W_DATA;
                end
            end
            ST_W_USER: begin
                if (i_reg_in_ack) begin
                    ack_s       = 1'b1;
                    state_nxt_s = ST_W_RESP;
                end else begin
                    state_nxt_s = ST_W_USER;
                end
            end
            ST_W_RESP: begin
                if (i_bready) begin
                    b_hs_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_W_RESP;
                end
            end
            ST_R_USER: begin
                if (i_reg_out_rdy) begin
                    rdy_s       = 1'b1;
                    state_nxt_s = ST_R_RESP;
                end else begin
                    state_nxt_s = ST_R_USER;
                end
            end
            ST_R_RESP: begin
                if (i_rready) begin
                    r_hs_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_R_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch the access address on either address handshake; held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_reg_address <= '0;
        end else if (aw_hs_s) begin
            o_reg_address <= i_awaddr;
        end else if (ar_hs_s) begin
            o_reg_address <= i_araddr;
        end
    end

    // Capture masked write data and raise the one-cycle write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_reg_in_data <= 32'h0000_0000;
            o_reg_in_rdy  <= 1'b0;
        end else begin
            o_reg_in_rdy <= w_hs_s;
            if (w_hs_s) begin
                o_reg_in_data <= mask_wdata(i_wdata, i_wstrb);
            end
        end
    end

    // Write response: set on user ack, cleared when the master accepts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_bvalid <= 1'b0;
            o_bresp  <= RESP_OKAY;
        end else if (ack_s) begin
            o_bvalid <= 1'b1;
            o_bresp  <= resp_code(i_reg_invalid_addr);
        end else if (b_hs_s) begin
            o_bvalid <= 1'b0;
        end
    end

    // One-cycle read request strobe following the read address handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_reg_out_req <= 1'b0;
        end else begin
            o_reg_out_req <= ar_hs_s;
        end
    end

    // Read response: capture user data on rdy, hold until the master accepts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rvalid <= 1'b0;
            o_rdata  <= 32'h0000_0000;
            o_rresp  <= RESP_OKAY;
        end else if (rdy_s) begin
            o_rvalid <= 1'b1;
            o_rdata  <= i_reg_out_data;
            o_rresp  <= resp_code(i_reg_invalid_addr);
        end else if (r_hs_s) begin
            o_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: a vector table of single
// transactions plus hand-written sequences for the address collision and
// mid-transaction reset cases. Responses are checked through a scoreboard.
module tb_axi_lite_reg_slave;

    logic        clk;
    logic        rst_n;
    logic        i_awvalid;
    logic [15:0] i_awaddr;
    logic        o_awready;
    logic        i_wvalid;
    logic        o_wready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        o_bvalid;
    logic        i_bready;
    logic [1:0]  o_bresp;
    logic        i_arvalid;
    logic        o_arready;
    logic [15:0] i_araddr;
    logic        o_rvalid;
    logic        i_rready;
    logic [1:0]  o_rresp;
    logic [31:0] o_rdata;
    logic [15:0] o_reg_address;
    logic        i_reg_invalid_addr;
    logic        o_reg_in_rdy;
    logic        i_reg_in_ack;
    logic [31:0] o_reg_in_data;
    logic        o_reg_out_req;
    logic        i_reg_out_rdy;
    logic [31:0] i_reg_out_data;

    axi_lite_reg_slave #(.ADDR_WIDTH(16)) dut (
        .clk                (clk),
        .rst                (rst_n),
        .i_awvalid          (i_awvalid),
        .i_awaddr           (i_awaddr),
        .o_awready          (o_awready),
        .i_wvalid           (i_wvalid),
        .o_wready           (o_wready),
        .i_wdata            (i_wdata),
        .i_wstrb            (i_wstrb),
        .o_bvalid           (o_bvalid),
        .i_bready           (i_bready),
        .o_bresp            (o_bresp),
        .i_arvalid          (i_arvalid),
        .o_arready          (o_arready),
        .i_araddr           (i_araddr),
        .o_rvalid           (o_rvalid),
        .i_rready           (i_rready),
        .o_rresp            (o_rresp),
        .o_rdata            (o_rdata),
        .o_reg_address      (o_reg_address),
        .i_reg_invalid_addr (i_reg_invalid_addr),
        .o_reg_in_rdy       (o_reg_in_rdy),
        .i_reg_in_ack       (i_reg_in_ack),
        .o_reg_in_data      (o_reg_in_data),
        .o_reg_out_req      (o_reg_out_req),
        .i_reg_out_rdy      (i_reg_out_rdy),
        .i_reg_out_data     (i_reg_out_data)
    );

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        inv;
        int          dly;
        int          hold;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic ready_of(input int which);
        case (which)
            0:       return o_awready;
            1:       return o_wready;
            default: return o_arready;
        endcase
    endfunction

    // Wait (bounded) for the selected ready at a negedge, then step past the handshake edge.
    task automatic wait_ready(input int which, input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready_of(which)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(nm, {63'd0, ok}, 64'd1);
        if (ok) @(negedge clk);
    endtask

    task automatic pop_check(input string nm, input logic [1:0] resp, input logic [31:0] data, input bit chk_data);
        exp_t e;
        chk({nm, "_sb_nonempty"}, {63'd0, (sb_q.size() != 0)}, 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({nm, "_resp"}, {62'd0, resp}, {62'd0, e.resp});
            if (chk_data) chk({nm, "_data"}, {32'd0, data}, {32'd0, e.data});
        end
    endtask

    task automatic do_write(input vec_t v, input bit keep_ar, input bit abort);
        bit   ok;
        int   n;
        exp_t e;
        i_awvalid = 1'b1;
        i_awaddr  = v.addr;
        if (keep_ar) i_arvalid = 1'b1;
        wait_ready(0, "aw_handshake", ok);
        i_awvalid = 1'b0;
        i_awaddr  = 16'hFFFF;
        if (!ok) return;
        chk("wr_reg_address", {48'd0, o_reg_address}, {48'd0, v.addr});
        if (keep_ar) chk("ar_blocked_during_write", {63'd0, o_arready}, 64'd0);
        i_wvalid = 1'b1;
        i_wdata  = v.data;
        i_wstrb  = v.strb;
        wait_ready(1, "w_handshake", ok);
        i_wvalid = 1'b0;
        i_wdata  = 32'h0BAD_0BAD;
        if (!ok) return;
        chk("in_rdy_pulse", {63'd0, o_reg_in_rdy}, 64'd1);
        chk("in_data", {32'd0, o_reg_in_data}, {32'd0, v.exp_data});
        if (abort) return;
        for (int i = 0; i < v.dly; i++) begin
            @(negedge clk);
            chk("in_rdy_single", {63'd0, o_reg_in_rdy}, 64'd0);
            chk("bvalid_before_ack", {63'd0, o_bvalid}, 64'd0);
        end
        i_reg_in_ack       = 1'b1;
        i_reg_invalid_addr = v.inv;
        e.resp = v.exp_resp;
        e.data = 32'h0;
        sb_q.push_back(e);
        @(negedge clk);
        i_reg_in_ack       = 1'b0;
        i_reg_invalid_addr = 1'b0;
        n = 0;
        while (!o_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bvalid_latency", n, 64'd0);
        if (!o_bvalid) return;
        pop_check("bresp", o_bresp, 32'h0, 1'b0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("bvalid_hold", {63'd0, o_bvalid}, 64'd1);
            chk("bresp_hold", {62'd0, o_bresp}, {62'd0, v.exp_resp});
        end
        i_bready = 1'b1;
        @(negedge clk);
        i_bready = 1'b0;
        chk("bvalid_clear", {63'd0, o_bvalid}, 64'd0);
        chk("wr_addr_stable", {48'd0, o_reg_address}, {48'd0, v.addr});
    endtask

    task automatic do_read(input vec_t v);
        bit   ok;
        int   n;
        exp_t e;
        i_arvalid = 1'b1;
        i_araddr  = v.addr;
        wait_ready(2, "ar_handshake", ok);
        i_arvalid = 1'b0;
        i_araddr  = 16'hFFFF;
        if (!ok) return;
        chk("rd_reg_address", {48'd0, o_reg_address}, {48'd0, v.addr});
        chk("out_req_pulse", {63'd0, o_reg_out_req}, 64'd1);
        for (int i = 0; i < v.dly; i++) begin
            @(negedge clk);
            chk("out_req_single", {63'd0, o_reg_out_req}, 64'd0);
            chk("rvalid_before_rdy", {63'd0, o_rvalid}, 64'd0);
        end
        i_reg_out_rdy      = 1'b1;
        i_reg_out_data     = v.data;
        i_reg_invalid_addr = v.inv;
        e.resp = v.exp_resp;
        e.data = v.exp_data;
        sb_q.push_back(e);
        @(negedge clk);
        i_reg_out_rdy      = 1'b0;
        i_reg_out_data     = 32'h5555_AAAA;
        i_reg_invalid_addr = 1'b0;
        n = 0;
        while (!o_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_latency", n, 64'd0);
        if (!o_rvalid) return;
        pop_check("rresp", o_rresp, o_rdata, 1'b1);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("rvalid_hold", {63'd0, o_rvalid}, 64'd1);
            chk("rdata_hold", {32'd0, o_rdata}, {32'd0, v.exp_data});
        end
        i_rready = 1'b1;
        @(negedge clk);
        i_rready = 1'b0;
        chk("rvalid_clear", {63'd0, o_rvalid}, 64'd0);
        chk("rdata_retained", {32'd0, o_rdata}, {32'd0, v.exp_data});
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctrl"}, {52'd0, o_awready, o_arready, o_wready, o_bvalid, o_bresp,
                            o_rvalid, o_rresp, o_reg_in_rdy, o_reg_out_req}, 64'd0);
        chk({nm, "_data"}, {o_rdata, o_reg_in_data}, 64'd0);
        chk({nm, "_addr"}, {48'd0, o_reg_address}, 64'd0);
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        //        wr    addr      data           strb  inv   dly hold exp_data       resp
        vecs[0] = '{1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 1'b0, 1, 0, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{1'b1, 16'h0040, 32'hCAFEF00D, 4'hF, 1'b1, 2, 1, 32'hCAFEF00D, 2'b10};
        vecs[2] = '{1'b1, 16'h0004, 32'h01234567, 4'hF, 1'b0, 1, 0, 32'h01234567, 2'b00};
        vecs[3] = '{1'b1, 16'h000C, 32'h11223344, 4'h5, 1'b0, 1, 0, 32'h00220044, 2'b00};
        vecs[4] = '{1'b0, 16'h0010, 32'h10000000, 4'h0, 1'b0, 2, 3, 32'h10000000, 2'b00};
        vecs[5] = '{1'b0, 16'h0014, 32'hA5A5A5A5, 4'h0, 1'b1, 1, 0, 32'hA5A5A5A5, 2'b10};
        vecs[6] = '{1'b1, 16'h0020, 32'hFFFFFFFF, 4'hA, 1'b0, 3, 2, 32'hFF00FF00, 2'b00};

        rst_n = 1'b0;
        i_awvalid = 1'b0; i_awaddr = 16'h0; i_wvalid = 1'b0; i_wdata = 32'h0;
        i_wstrb = 4'h0; i_bready = 1'b0; i_arvalid = 1'b0; i_araddr = 16'h0;
        i_rready = 1'b0; i_reg_invalid_addr = 1'b0; i_reg_in_ack = 1'b0;
        i_reg_out_rdy = 1'b0; i_reg_out_data = 32'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_awready", {63'd0, o_awready}, 64'd1);
        chk("idle_arready", {63'd0, o_arready}, 64'd1);
        chk("idle_wready", {63'd0, o_wready}, 64'd0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i], 1'b0, 1'b0);
            else               do_read(vecs[i]);
            @(negedge clk);
        end

        // Simultaneous AW and AR: write first, then the pending read.
        v = '{1'b1, 16'h0030, 32'h0000BEEF, 4'h3, 1'b0, 1, 0, 32'h0000BEEF, 2'b00};
        do_write(v, 1'b1, 1'b0);
        v = '{1'b0, 16'h0034, 32'h77665544, 4'h0, 1'b0, 1, 1, 32'h77665544, 2'b00};
        do_read(v);
        @(negedge clk);

        // Reset while the write waits for the user ack.
        v = '{1'b1, 16'h0050, 32'h12345678, 4'hF, 1'b0, 1, 0, 32'h12345678, 2'b00};
        do_write(v, 1'b0, 1'b1);
        @(negedge clk);
        i_reg_in_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_ack_no_bvalid", {63'd0, o_bvalid}, 64'd0);
        end
        i_reg_in_ack = 1'b0;
        v = '{1'b0, 16'h0060, 32'h0F0F0F0F, 4'h0, 1'b0, 1, 0, 32'h0F0F0F0F, 2'b00};
        do_read(v);
        @(negedge clk);

        chk("scoreboard_drained", sb_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
